// File: rtl/mem_port_arbiter_if.sv
// One requester's view of the shared memory port: a valid/ready request channel
// and a response that arrives one cycle after the request is accepted.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 13
);
  logic              rq_valid;
  logic              rq_ready;
  logic [ADDR_W-1:0] rq_addr;
  logic [31:0]       rq_wdata;
  logic [3:0]        rq_be;
  logic              rq_we;
  logic              rq_lock;
  logic              rs_valid;
  logic [31:0]       rs_rdata;

  modport master (
    output rq_valid, rq_addr, rq_wdata, rq_be, rq_we, rq_lock,
    input  rq_ready, rs_valid, rs_rdata
  );

  modport slave (
    input  rq_valid, rq_addr, rq_wdata, rq_be, rq_we, rq_lock,
    output rq_ready, rs_valid, rs_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the CPU (req0) and the DMA engine (req1) for port B
// of the main-memory BRAM, with a bounded burst lock and one-cycle read latency.
module mem_port_arbiter #(
  parameter int MEM_SIZE = 8192,
  parameter int MAX_LOCK = 8,
  localparam int ADDR_W  = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave req0,
  mem_port_arbiter_if.slave req1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       rs_pending;

  logic [1:0]       valid;
  logic [1:0]       accept;
  logic             cont_lock;
  logic             sel_lock;
  logic [CNT_W-1:0] cnt_next;
  logic             lock_take;

  assign valid = {req1.rq_valid, req0.rq_valid};

  // A locked owner that drops valid releases the lock within the same cycle,
  // so the other requester falls through to the plain round-robin rules.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    accept = 2'b00;
    if (state == LOCKED0 && valid[0]) begin
      accept = 2'b01;
    end else if (state == LOCKED1 && valid[1]) begin
      accept = 2'b10;
    end else if (valid == 2'b11) begin
      accept = last_grant ? 2'b01 : 2'b10;
    end else begin
      accept = valid;
    end
  end

  assign req0.rq_ready = accept[0];
  assign req1.rq_ready = accept[1];

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    mem_we    = 1'b0;
    sel_lock  = 1'b0;
    if (accept[0]) begin
      mem_addr  = req0.rq_addr;
      mem_wdata = req0.rq_wdata;
      mem_be    = req0.rq_be;
      mem_we    = req0.rq_we;
      sel_lock  = req0.rq_lock;
    end else if (accept[1]) begin
      mem_addr  = req1.rq_addr;
      mem_wdata = req1.rq_wdata;
      mem_be    = req1.rq_be;
      mem_we    = req1.rq_we;
      sel_lock  = req1.rq_lock;
    end
  end

  // Beat count restarts at 1 whenever the accepted beat is not a continuation
  // of the current owner's lock; the final allowed beat forces a release.
  assign cont_lock = (accept[0] && state == LOCKED0) || (accept[1] && state == LOCKED1);
  assign cnt_next  = cont_lock ? lock_cnt + CNT_W'(1) : CNT_W'(1);
  assign lock_take = sel_lock && (cnt_next < MAX_LOCK_C);

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= UNLOCKED;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rs_pending <= 2'b00;
    end else begin
      rs_pending <= accept;
      if (|accept) begin
        last_grant <= accept[1];
        if (lock_take) begin
          state    <= accept[1] ? LOCKED1 : LOCKED0;
          lock_cnt <= cnt_next;
        end else begin
          state    <= UNLOCKED;
          lock_cnt <= '0;
        end
      end else if (state != UNLOCKED) begin
        state    <= UNLOCKED;
        lock_cnt <= '0;
      end
    end
  end

  // Memory read data is registered inside the BRAM, so it lines up with rs_pending.
  assign req0.rs_valid = rs_pending[0];
  assign req1.rs_valid = rs_pending[1];
  assign req0.rs_rdata = rs_pending[0] ? mem_rdata : 32'h0;
  assign req1.rs_rdata = rs_pending[1] ? mem_rdata : 32'h0;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the read/write port (port B) of the dual-port BRAM main memory. Requester 0 is the CPU load/store unit. Requester 1 is the DMA/loader engine.

- Each requester uses a valid/ready request handshake and receives a one-cycle-later response.
- Arbitration is round-robin, with an optional bounded burst lock.
- The block accounts for the memory's one-cycle registered read latency.

## Interface
Parameters:
- MEM_SIZE, 8192: memory size in bytes; ADDR_W = $clog2(MEM_SIZE).
- MAX_LOCK, 8: maximum consecutive accepted beats under one lock; must be ≥1.

Ports (k = 0, 1):
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rq_valid_k  in  1  requester k has a request.
- rq_ready_k  out  1  request accepted this cycle (combinational).
- rq_addr_k  in  ADDR_W  byte address; low 2 bits are passed through untouched.
- rq_wdata_k  in  32  write data.
- rq_be_k  in  4  byte enables.
- rq_we_k  in  1  1 = write, 0 = read.
- rq_lock_k  in  1  hold the grant for the next beat.
- rs_valid_k  out  1  response for k's accepted request (registered).
- rs_rdata_k  out  32  memory data word; valid only with rs_valid_k.
- mem_addr  out  ADDR_W  to memory addr_b.
- mem_wdata  out  32  to memory data_i_b.
- mem_be  out  4  to memory data_en_b.
- mem_we  out  1  to memory write_en_b.
- mem_rdata  in  32  from memory data_o_b.

## Operation
- State machine states: UNLOCKED, LOCKED0, LOCKED1. Registers: state, last_grant (1 bit), lock_cnt ($clog2(MAX_LOCK+1) bits), rs_pending_k (2 bits).

Grant, UNLOCKED:
- Exactly one requester valid: it is granted.
- Both valid: grant ~last_grant.
- rq_ready_k = grant_k & rq_valid_k. At most one ready per cycle.

Grant, LOCKEDk:
- Owner valid: only the owner may be granted.
- Owner not valid: the lock is released combinationally, and the other requester may be granted that same cycle by the UNLOCKED rules.

Memory outputs:
- On acceptance, mem_* carry the granted requester's fields and mem_we = rq_we.
- With no acceptance, mem_addr = 0, mem_wdata = 0, mem_be = 0, mem_we = 0.

State update on acceptance by k:
- last_grant <= k.
- If rq_lock_k = 1 and the new beat count < MAX_LOCK: state <= LOCKEDk and lock_cnt increments. lock_cnt is cleared on entry from UNLOCKED and counts accepted beats, including the first.
- If rq_lock_k = 1 and the beat count reaches MAX_LOCK: forced release. state <= UNLOCKED, lock_cnt <= 0, last_grant = k, so the other requester wins the next conflict.
- If rq_lock_k = 0: state <= UNLOCKED, lock_cnt <= 0.
- MAX_LOCK = 1 disables locking entirely.

Other state updates:
- Release because the owner is not valid: state <= UNLOCKED, lock_cnt <= 0.
- No acceptance: last_grant is unchanged.

Responses:
- Every accepted request, read or write, produces exactly one rs_valid_k pulse.
- rs_rdata_k = mem_rdata, routed by the registered owner.
- For writes, the returned data is the word before the write (read-before-write memory behaviour); requesters ignore it.
- rs_rdata_k is 0 when rs_valid_k is 0.

## Timing
- Request accepted at edge N → memory samples at edge N → rs_valid_k high during cycle N+1, with rs_rdata_k = mem_rdata.
- Throughput is one request per cycle. Back-to-back requests from alternating requesters are allowed, and responses keep issue order.
- rq_ready_k is combinational from valids, state and last_grant. It must not depend on rs_*.
- A requester must hold all rq_* fields stable while rq_valid_k = 1 and rq_ready_k = 0.

Reset values (asynchronous):
- state = UNLOCKED, last_grant = 1 (requester 0 wins the first conflict), lock_cnt = 0.
- rs_valid_0/1 = 0, rs_rdata_0/1 = 0.
- mem_we = 0, mem_be = 0.

Reset during operation:
- An in-flight response is dropped: rs_valid is cleared immediately.
- A memory write already sampled on a prior edge stays committed. No partial state survives.

Simultaneous events:
- Lock expiry plus the other requester waiting: the other is granted on the next cycle.
- Both valid plus the owner's lock: the owner wins regardless of last_grant.

## Test plan
- Single read: after a 4-byte write of 0xDEADBEEF to 0x10, req0 reads 0x10 → rq_ready_0 same cycle, rs_valid_0 one cycle later with rs_rdata_0 = 0xDEADBEEF, rs_valid_1 = 0.
- Conflict round-robin: after reset, both valid with reads continuously for 4 cycles → grants alternate 0, 1, 0, 1. Responses alternate one cycle later with correct per-address data.
- Byte-enable write: req1 writes 0x11223344 with be = 4'b0101 to a word holding 0xAAAAAAAA. A subsequent read returns 0xAA22AA44, and the write response carries the old value 0xAAAAAAAA.
- Lock bound: MAX_LOCK = 8, req1 valid with lock held high, req0 continuously valid → req1 gets exactly 8 consecutive grants, then req0 is granted on the 9th cycle.
- Lock release on drop: req0 locked, then drops valid for one cycle while req1 is valid → req1 is granted in that same cycle and state returns to UNLOCKED.
- Async reset mid-flight: assert rst in the cycle after an accepted read, between edges → rs_valid_0 falls immediately, and after deassertion the first conflict is granted to req0.
